// File: rtl/speaker_playback.sv
// Audio playback: walks the capture region, fetching one word per sample tick
// and shifting its low 12 bits to a 12-bit SPI DAC (16-bit frame, normal mode).
module speaker_playback #(
    parameter logic [23:0] AUDIO_START_ADDR = 24'h010000,
    parameter logic [23:0] AUDIO_END_ADDR   = 24'h160000,
    parameter int          SAMPLE_PERIOD    = 4096
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        start_play,
    output logic        play_to_mem_req,
    output logic [23:0] play_to_mem_addr,
    input  logic        mem_to_play_ack,
    input  logic [15:0] mem_to_play_data,
    output logic        dac_sync_n,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        playing,
    output logic        done_playing,
    output logic        underrun
);
    localparam int             PCW     = $clog2(SAMPLE_PERIOD);
    localparam logic [PCW-1:0] PC_LAST = PCW'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, READ, SHIFT, QUIET, WAIT} state_t;

    state_t         state, state_n;
    logic [PCW-1:0] pc, pc_n;
    logic [23:0]    addr_r, addr_n;
    logic [15:0]    frame, frame_n;
    logic [2:0]     ph, ph_n;
    logic [3:0]     bit_idx, bit_n;
    logic           hold, hold_n;
    logic           sync_n_n, sclk_n, din_n, done_n, under_n;
    logic           tick, go;

    assign tick             = (pc == '0);
    // After the last address, start_play must drop before a new run can begin.
    assign go               = start_play && !hold;
    assign play_to_mem_req  = (state == READ);
    assign play_to_mem_addr = play_to_mem_req ? addr_r : 24'h0;
    assign playing          = (state != IDLE);

    always_comb begin
        state_n  = state;
        addr_n   = addr_r;
        frame_n  = frame;
        ph_n     = ph;
        bit_n    = bit_idx;
        hold_n   = hold && start_play;
        sync_n_n = 1'b1;
        sclk_n   = 1'b1;
        din_n    = 1'b0;
        done_n   = 1'b0;
        under_n  = tick && (state == READ || state == SHIFT || state == QUIET);

        if (state == IDLE)
            pc_n = go ? PCW'(1) : '0;
        else
            pc_n = (pc == PC_LAST) ? '0 : pc + 1'b1;

        case (state)
            IDLE: begin
                addr_n = AUDIO_START_ADDR;
                ph_n   = '0;
                bit_n  = '0;
                if (go)
                    state_n = READ;
            end
            READ: begin
                if (mem_to_play_ack) begin
                    // Top nibble zero: PD1/PD0 = 00 selects normal DAC mode.
                    frame_n  = mem_to_play_data & 16'h0FFF;
                    ph_n     = '0;
                    bit_n    = '0;
                    sync_n_n = 1'b0;
                    din_n    = frame_n[15];
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                sync_n_n = 1'b0;
                din_n    = dac_din;
                if (ph == 3'd5) begin
                    ph_n = '0;
                    if (bit_idx == 4'd15) begin
                        sync_n_n = 1'b1;
                        din_n    = 1'b0;
                        state_n  = QUIET;
                    end else begin
                        bit_n = bit_idx + 4'd1;
                        din_n = frame[4'd15 - bit_n];
                    end
                end else begin
                    ph_n   = ph + 3'd1;
                    sclk_n = (ph_n < 3'd3);
                end
            end
            QUIET: begin
                if (ph == 3'd3) begin
                    ph_n = '0;
                    if (addr_r == AUDIO_END_ADDR) begin
                        done_n  = 1'b1;
                        hold_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        addr_n  = addr_r + 24'd1;
                        state_n = WAIT;
                    end
                end else begin
                    ph_n = ph + 3'd1;
                end
            end
            WAIT: begin
                if (tick)
                    state_n = start_play ? READ : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= '0;
            addr_r       <= AUDIO_START_ADDR;
            frame        <= '0;
            ph           <= '0;
            bit_idx      <= '0;
            hold         <= 1'b0;
            dac_sync_n   <= 1'b1;
            dac_sclk     <= 1'b1;
            dac_din      <= 1'b0;
            done_playing <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            addr_r       <= addr_n;
            frame        <= frame_n;
            ph           <= ph_n;
            bit_idx      <= bit_n;
            hold         <= hold_n;
            dac_sync_n   <= sync_n_n;
            dac_sclk     <= sclk_n;
            dac_din      <= din_n;
            done_playing <= done_n;
            underrun     <= under_n;
        end
    end

endmodule

// File: tb/tb_speaker_playback.sv
// Bench for speaker_playback: three channels with different ranges/periods,
// a latency-programmable memory responder and a DAC frame decoder per channel.
module tb_speaker_playback;
    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   ncmp    = 0;
    int   nerr    = 0;
    int   cyc     = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    localparam logic [23:0] ST [3] = '{24'h010000, 24'h000000, 24'h010000};
    localparam logic [23:0] EN [3] = '{24'h160000, 24'h000003, 24'h160000};
    localparam int          SP [3] = '{4096, 200, 128};

    for (genvar g = 0; g < 3; g++) begin : ch
        logic        start = 1'b0;
        logic        ack   = 1'b0;
        logic [15:0] data  = 16'h0;
        logic        req, sync_n, sclk, din, playing, done, und;
        logic [23:0] addr;
        int          lat    = 2;
        int          nfall  = 0;
        int          ndone  = 0;
        int          nund   = 0;
        int          spexp  = 0;
        bit          sp_chk = 1'b0;
        logic [15:0] sbq[$];

        speaker_playback #(
            .AUDIO_START_ADDR(ST[g]),
            .AUDIO_END_ADDR  (EN[g]),
            .SAMPLE_PERIOD   (SP[g])
        ) dut (
            .sys_clk         (sys_clk),
            .rst             (rst),
            .start_play      (start),
            .play_to_mem_req (req),
            .play_to_mem_addr(addr),
            .mem_to_play_ack (ack),
            .mem_to_play_data(data),
            .dac_sync_n      (sync_n),
            .dac_sclk        (sclk),
            .dac_din         (din),
            .playing         (playing),
            .done_playing    (done),
            .underrun        (und)
        );

        // Memory: ack on the lat-th cycle of a request; expected frame queued here.
        initial begin : resp
            int          rc;
            logic [23:0] ea;
            logic        pst;
            rc = 0; ea = ST[g]; pst = 1'b0;
            forever begin
                @(negedge sys_clk);
                if (start && !pst) ea = ST[g];
                pst = start;
                ack = 1'b0;
                if (rst || !req) begin
                    rc = 0;
                end else begin
                    rc++;
                    if (rc == lat) begin
                        check($sformatf("ch%0d_addr", g), addr, ea);
                        data = 16'hF000 | {4'h0, 12'hABC ^ ea[11:0]};
                        ack  = 1'b1;
                        sbq.push_back(data & 16'h0FFF);
                        ea = ea + 24'd1;
                        rc = 0;
                    end
                end
            end
        end

        // DAC decoder: bits taken on sclk falling edges while sync_n is low.
        initial begin : mon
            logic        ps, pk;
            int          low, nb, lastf;
            bit          havep;
            logic [15:0] sh;
            ps = 1'b1; pk = 1'b1; low = 0; nb = 0; lastf = 0; havep = 1'b0; sh = '0;
            forever begin
                @(negedge sys_clk);
                if (rst) begin
                    sbq.delete();
                    low = 0; nb = 0; havep = 1'b0; ps = 1'b1; pk = 1'b1;
                end else begin
                    if (done) ndone++;
                    if (und)  nund++;
                    if (!sync_n) begin
                        low++;
                        if (ps) begin
                            nfall++;
                            if (sp_chk && havep)
                                check($sformatf("ch%0d_spacing", g), cyc - lastf, spexp);
                            havep = sp_chk;
                            lastf = cyc;
                        end
                        if (pk && !sclk) begin
                            sh = {sh[14:0], din};
                            nb++;
                        end
                    end else if (!ps) begin
                        check($sformatf("ch%0d_sync_low", g), low, 96);
                        check($sformatf("ch%0d_nbits", g), nb, 16);
                        check($sformatf("ch%0d_sb_pending", g), sbq.size() > 0, 1);
                        if (sbq.size() > 0)
                            check($sformatf("ch%0d_frame", g), sh, sbq.pop_front());
                        low = 0; nb = 0;
                    end
                    ps = sync_n;
                    pk = sclk;
                end
            end
        end
    end

    function automatic int falls(input int i);
        case (i)
            0:       return ch[0].nfall;
            1:       return ch[1].nfall;
            default: return ch[2].nfall;
        endcase
    endfunction

    task automatic wait_fall(input int i, input int n, input int budget);
        int k;
        k = 0;
        while (falls(i) < n && k < budget) begin
            @(negedge sys_clk); #1;
            k++;
        end
        check($sformatf("ch%0d_fall_%0d_seen", i, n), falls(i) >= n, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        repeat (3) @(negedge sys_clk);
        check("rst_sync_n",  {ch[0].sync_n, ch[1].sync_n, ch[2].sync_n}, 3'b111);
        check("rst_sclk",    {ch[0].sclk, ch[1].sclk, ch[2].sclk}, 3'b111);
        check("rst_din",     {ch[0].din, ch[1].din, ch[2].din}, 3'b000);
        check("rst_req",     {ch[0].req, ch[1].req, ch[2].req}, 3'b000);
        check("rst_addr",    ch[0].addr | ch[1].addr | ch[2].addr, 24'h0);
        check("rst_playing", {ch[0].playing, ch[1].playing, ch[2].playing}, 3'b000);
        check("rst_flags",   {ch[0].done, ch[1].done, ch[2].und, ch[0].und}, 4'b0000);
        rst = 1'b0;

        // Single frame (0xFABC -> 0x0ABC), then stop during bit 7.
        ch[0].lat = 2;
        ch[0].start = 1'b1;
        wait_fall(0, 1, 50);
        repeat (50) @(negedge sys_clk);
        ch[0].start = 1'b0;
        repeat (4043) @(negedge sys_clk);
        #1;
        check("stop_playing_at_tick", ch[0].playing, 1'b1);
        @(negedge sys_clk); #1;
        check("stop_idle_after_tick", ch[0].playing, 1'b0);
        check("stop_frames", ch[0].nfall, 1);
        check("stop_no_done", ch[0].ndone, 0);

        // Continuous play, latency 3: 4096-cycle spacing, sequential addresses.
        ch[0].lat = 3;
        ch[0].spexp = 4096;
        ch[0].sp_chk = 1'b1;
        ch[0].start = 1'b1;
        wait_fall(0, 4, 9000);
        check("cont_no_underrun", ch[0].nund, 0);

        // Reset in the middle of bit 4 (sync low, sclk low, din high).
        repeat (27) @(negedge sys_clk);
        rst = 1'b1;
        #1;
        check("midrst_sync_n",  ch[0].sync_n, 1'b1);
        check("midrst_sclk",    ch[0].sclk, 1'b1);
        check("midrst_din",     ch[0].din, 1'b0);
        check("midrst_req",     ch[0].req, 1'b0);
        check("midrst_addr",    ch[0].addr, 24'h0);
        check("midrst_playing", ch[0].playing, 1'b0);
        ch[0].start = 1'b0;
        ch[0].sp_chk = 1'b0;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        #1;
        check("postrst_idle", {ch[0].playing, ch[0].req, ch[0].sync_n}, 3'b001);

        // End of range 0..3 with start_play held high.
        ch[1].lat = 2;
        ch[1].spexp = 200;
        ch[1].sp_chk = 1'b1;
        ch[1].start = 1'b1;
        k = 0;
        while (ch[1].ndone < 1 && k < 3000) begin
            @(negedge sys_clk); #1;
            k++;
        end
        check("end_done_seen", ch[1].ndone, 1);
        check("end_frames_at_done", ch[1].nfall, 4);
        repeat (600) @(negedge sys_clk);
        #1;
        check("end_frames_total", ch[1].nfall, 4);
        check("end_done_once", ch[1].ndone, 1);
        check("end_idle", {ch[1].playing, ch[1].req}, 2'b00);
        ch[1].start = 1'b0;

        // Underrun: period 128, latency 40 -> one underrun per frame, 256 spacing.
        ch[2].lat = 40;
        ch[2].spexp = 256;
        ch[2].sp_chk = 1'b1;
        ch[2].start = 1'b1;
        wait_fall(2, 4, 2000);
        check("und_before_4th", ch[2].nund, 3);
        ch[2].start = 1'b0;
        repeat (600) @(negedge sys_clk);
        #1;
        check("und_total", ch[2].nund, 4);
        check("und_frames", ch[2].nfall, 4);
        check("und_no_done", ch[2].ndone, 0);
        check("und_idle", ch[2].playing, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/speaker_playback.md
# speaker_playback

Playback stage that consumes the 16-bit samples the microphone capture path writes into the audio memory region. On `start_play` it walks addresses `AUDIO_START_ADDR`..`AUDIO_END_ADDR` inclusive. For each address it reads one word over a req/ack memory port and shifts its low 12 bits to a 12-bit SPI DAC at a fixed sample period, which matches the capture rate. It sits between the memory arbiter and the DAC pads, and is controlled by the audio controller.

## Interface
- `AUDIO_START_ADDR`, 24'h10000: first sample address.
- `AUDIO_END_ADDR`, 24'h160000: last sample address, inclusive.
- `SAMPLE_PERIOD`, 4096: `sys_clk` cycles between the starts of consecutive DAC frames (about 16 kHz). Must be greater than 110.
- `sys_clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start_play` in 1: level signal. High starts playback and keeps it running.
- `play_to_mem_req` out 1: read request.
- `play_to_mem_addr` out 24: read address. Valid while `req` is high, otherwise 0.
- `mem_to_play_ack` in 1: one-cycle pulse; data is valid in the same cycle.
- `mem_to_play_data` in 16: read word. Bits [11:0] are the sample; bits [15:12] are ignored.
- `dac_sync_n` out 1: frame select, active low.
- `dac_sclk` out 1: serial clock, idles high. The DAC latches on the falling edge.
- `dac_din` out 1: serial data, MSB first.
- `playing` out 1: high in every state except IDLE.
- `done_playing` out 1: one-cycle pulse after the last address has been sent.
- `underrun` out 1: one-cycle pulse when a sample tick is missed.

## Operation
- States: IDLE, READ, SHIFT, QUIET, WAIT.
- Period counter `pc`, range 0..`SAMPLE_PERIOD`-1:
  - Cleared in IDLE.
  - Otherwise increments each cycle and wraps to 0.
  - A "tick" is `pc`==0.
- **IDLE**:
  - `addr_r` <= `AUDIO_START_ADDR`.
  - If `start_play` is high, go to READ. That cycle counts as `pc`=0.
- **READ**:
  - `play_to_mem_req`=1 and `play_to_mem_addr`=`addr_r`.
  - On `ack`, latch `frame` = {4'b0000, `data`[11:0]}. The top bits are PD1/PD0=00, which is normal mode.
  - Go to SHIFT.
- **SHIFT**:
  - 16 bits, 6 cycles per bit, phase counter `ph` 0..5.
  - At `ph`=0: `dac_sclk`<=1 and `dac_din`<=`frame`[15-bit].
  - At `ph`=3: `dac_sclk`<=0.
  - `dac_sync_n`=0 for the whole state.
  - After bit 0 at `ph`=5, go to QUIET.
- **QUIET**:
  - `dac_sync_n`=1, `dac_sclk`=1, `dac_din`=0 for 4 cycles.
  - Then handle the end of the address range:
    - If `addr_r`==`AUDIO_END_ADDR`: pulse `done_playing` and go to IDLE.
    - Otherwise: `addr_r`+1 and go to WAIT.
- **WAIT**:
  - On a tick: go to READ if `start_play` is high, else go to IDLE.
  - No `done_playing` pulse on this exit.
- **Underrun**: a tick that occurs while in READ, SHIFT or QUIET pulses `underrun`. The frame in progress completes, and the next frame waits for the following tick.
- **Stop request**: `start_play` falling mid-frame never truncates the frame. The block stops only at WAIT.
- **Address arithmetic**: 24-bit, compared before incrementing. There is no wrap past `AUDIO_END_ADDR`.

## Timing
- Reset values:
  - `dac_sync_n`=1, `dac_sclk`=1, `dac_din`=0.
  - `req`=0, `addr`=0.
  - `playing`=0, `done_playing`=0, `underrun`=0.
  - State IDLE, all counters 0.
  - Reset asserted mid-frame forces these values immediately.
- Start: `start_play` sampled high at edge E makes `req` high after E.
- Request handshake:
  - `req` is held until `ack`.
  - `req` drops at the edge that samples `ack`.
  - `dac_sync_n` falls at that same edge, with bit 15 on `dac_din`.
- Frame length: 96 cycles with `sync_n` low, then 4 cycles quiet.
- `dac_sclk` shape:
  - High for 3 cycles, then low for 3 cycles.
  - `din` changes only while `sclk` is high, 3 cycles before each falling edge.
- Frame spacing: with an ack latency of L cycles, `sync_n` falls L+1 cycles after each tick, so consecutive falls are exactly `SAMPLE_PERIOD` cycles apart.
- `done_playing` asserts on the cycle after the last quiet cycle.

## Test plan
- **Reset**: assert `rst` mid-SHIFT. All outputs take their reset values within the same cycle, and the block stays IDLE with `start_play`=0.
- **Single frame**: ack latency 2, `data`=16'hFABC.
  - `din` sampled at `sclk` falling edges reads 0000_1010_1011_1100.
  - `sync_n` is low for 96 cycles.
- **Spacing**: continuous play with ack latency 3. Consecutive `sync_n` falling edges are exactly 4096 cycles apart, and addresses run 0x10000, 0x10001, ….
- **End of range**: `START`=0, `END`=3, `SAMPLE_PERIOD`=200.
  - Exactly 4 frames, at addresses 0..3.
  - One `done_playing` pulse, then IDLE and `playing`=0, even with `start_play` still high.
- **Stop mid-frame**: drop `start_play` during bit 7. The frame completes all 16 bits, the block returns to IDLE at the next tick, and `done_playing` stays 0.
- **Underrun**: `SAMPLE_PERIOD`=128, ack latency 40.
  - `underrun` pulses once per frame.
  - `sync_n` falls are 256 cycles apart.
